pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 16-bit, 3-stage (IF / ID / EX) core; replaces the pass-through branch control path.
- Arbitrates three sources of pipeline control: EX branch redirect, ID-vs-EX read-after-write hazard stall, and an external debug halt/single-step port.
- Drives PC hold/jump and the hold/flush controls of the if_id and id_ex pipeline registers.

Parameters:
- RA_W, 3, register-address width (8 GPRs)
- OFF_W, 6, branch offset width
- CNT_W, 16, width of the performance counters (PERF_CNT_EN only)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_jump_en_i  in  1  EX resolved a taken branch this cycle
- ex_jump_offset_i  in  OFF_W  EX branch offset
- id_rs1_addr_i  in  RA_W  ID source 1 address
- id_rs1_used_i  in  1  ID instruction reads rs1
- id_rs2_addr_i  in  RA_W  ID source 2 address
- id_rs2_used_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  RA_W  EX destination address
- ex_rd_wen_i  in  1  EX will write rd at the end of this cycle
- dbg_halt_req_i  in  1  level; request/keep the core halted
- dbg_step_i  in  1  one-cycle pulse; advance one cycle while halted
- pc_hold_o  out  1  PC keeps its value
- pc_jump_en_o  out  1  PC loads PC+offset
- pc_jump_offset_o  out  OFF_W  offset to PC
- if_id_hold_o  out  1  if_id keeps its contents
- if_id_flush_o  out  1  if_id loads a NOP
- id_ex_flush_o  out  1  id_ex loads a bubble (NOP, reg_wen=0)
- dbg_halted_o  out  1  registered; core is halted
- (PERF_CNT_EN) stall_cnt_o  out  CNT_W; flush_cnt_o  out  CNT_W

Behaviour:
- FSM: 2-bit state register {RUN, FLUSH, HALT, STEP}; reset -> RUN.
- Reset values: every output 0 while rst_n is low. dbg_halted_o is a flop reset to 0. Combinational outputs are forced to 0 by the reset state.
- Branch and hazard control is combinational (same-cycle) from the inputs; state-dependent gating is from the state flop.
- Branch accept (states RUN or STEP, ex_jump_en_i=1):
  - pc_jump_en_o=1; pc_jump_offset_o = ex_jump_offset_i.
  - if_id_flush_o=1 and id_ex_flush_o=1.
  - No hold outputs are asserted.
  - Next state is FLUSH.
- FLUSH (1 cycle):
  - ex_jump_en_i and the hazard check are ignored, since EX holds a bubble.
  - No control outputs are asserted.
  - Next state is HALT if dbg_halt_req_i=1, else RUN.
- Hazard:
  - haz = (id_rs1_used_i & rs1==ex_rd) | (id_rs2_used_i & rs2==ex_rd), qualified by ex_rd_wen_i. r0 is not special.
  - In RUN with haz=1 and no jump: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 for exactly that cycle. The bubble clears ex_rd_wen_i, so the stall self-terminates after 1 cycle.
- Priority: jump > hazard > debug halt. Hold and flush are never both asserted on the same register.
- RUN with dbg_halt_req_i=1 and no jump: next state HALT. This cycle still advances normally, or stalls if haz=1.
- HALT:
  - pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 every cycle (EX drains, then idles); dbg_halted_o=1.
  - dbg_halt_req_i=0 -> RUN.
  - Else dbg_step_i=1 -> STEP.
  - dbg_step_i is ignored outside HALT.
- STEP (1 cycle):
  - Behaves as RUN for exactly one cycle, including hazard stall and branch accept.
  - Next state is FLUSH if a jump was taken, else HALT. FLUSH then returns to HALT while the request is held.
- dbg_halted_o = registered (next_state==HALT); it is 1 in the cycle after entry.
- Async reset mid-branch or mid-halt returns to RUN with all outputs 0. There is no pending-jump memory.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments on each hazard-stall cycle.
  - flush_cnt_o increments on each accepted branch.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with ex_jump_en_i=1 -> all outputs 0; release -> RUN, and the next jump is accepted normally.
- Branch: RUN, ex_jump_en_i=1, offset=6'h3A -> same cycle pc_jump_en_o=1, offset 6'h3A, both flushes=1. Next cycle (FLUSH) a second ex_jump_en_i=1 is ignored, with all outputs 0.
- Hazard: rs1=3 used, ex_rd=3, ex_rd_wen_i=1 -> pc_hold_o=if_id_hold_o=id_ex_flush_o=1 for 1 cycle. Same inputs but id_rs1_used_i=0 -> no stall.
- Jump+hazard in the same cycle -> jump outputs only, no holds.
- Debug: raise dbg_halt_req_i -> dbg_halted_o=1 after 1 cycle with holds asserted. Pulse dbg_step_i -> exactly one cycle with holds=0, then back to HALT. Drop the request -> RUN, dbg_halted_o=0.
- Perf (macro on): 3 stalls + 2 branches -> stall_cnt_o=3, flush_cnt_o=2. Preload near all-ones -> the counters saturate.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: IF/ID/EX sequencer arbitrating EX branch redirect, ID/EX RAW stall and debug halt/step.
// Optional saturating stall/flush counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int RA_W  = 3,
    parameter int OFF_W = 6
`ifdef PIPE_CTRL_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_jump_en_i,
    input  logic [OFF_W-1:0] ex_jump_offset_i,
    input  logic [RA_W-1:0]  id_rs1_addr_i,
    input  logic             id_rs1_used_i,
    input  logic [RA_W-1:0]  id_rs2_addr_i,
    input  logic             id_rs2_used_i,
    input  logic [RA_W-1:0]  ex_rd_addr_i,
    input  logic             ex_rd_wen_i,
    input  logic             dbg_halt_req_i,
    input  logic             dbg_step_i,
    output logic             pc_hold_o,
    output logic             pc_jump_en_o,
    output logic [OFF_W-1:0] pc_jump_offset_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             dbg_halted_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {RUN, FLUSH, HALT, STEP} state_t;

    state_t r_state, w_next;
    logic   r_halted;
    logic   w_haz, w_live, w_jump, w_stall, w_idle;

    // Outputs are gated by rst_n so nothing leaks while reset is held.
    always_comb begin
        w_haz  = ex_rd_wen_i & ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                                (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
        w_live = rst_n & ((r_state == RUN) | (r_state == STEP));
        w_jump = w_live & ex_jump_en_i;
        w_stall = w_live & ~ex_jump_en_i & w_haz;
        w_idle = rst_n & (r_state == HALT);
        pc_jump_en_o     = w_jump;
        pc_jump_offset_o = w_jump ? ex_jump_offset_i : '0;
        if_id_flush_o    = w_jump;
        pc_hold_o        = w_stall | w_idle;
        if_id_hold_o     = w_stall | w_idle;
        id_ex_flush_o    = w_jump | w_stall | w_idle;
        dbg_halted_o     = r_halted;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     w_next = ex_jump_en_i ? FLUSH : (dbg_halt_req_i ? HALT : RUN);
            FLUSH:   w_next = dbg_halt_req_i ? HALT : RUN;
            HALT:    w_next = !dbg_halt_req_i ? RUN : (dbg_step_i ? STEP : HALT);
            STEP:    w_next = ex_jump_en_i ? FLUSH : HALT;
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALT);
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_jump && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized check of pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int RA_W  = 3;
    localparam int OFF_W = 6;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_jump_en_i = 1'b0;
    logic [OFF_W-1:0] ex_jump_offset_i = '0;
    logic [RA_W-1:0]  id_rs1_addr_i = '0;
    logic             id_rs1_used_i = 1'b0;
    logic [RA_W-1:0]  id_rs2_addr_i = '0;
    logic             id_rs2_used_i = 1'b0;
    logic [RA_W-1:0]  ex_rd_addr_i = '0;
    logic             ex_rd_wen_i = 1'b0;
    logic             dbg_halt_req_i = 1'b0;
    logic             dbg_step_i = 1'b0;
    logic             pc_hold_o, pc_jump_en_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o, dbg_halted_o;
    logic [OFF_W-1:0] pc_jump_offset_o;

    always #5 clk = ~clk;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    pipe_ctrl #(.RA_W(RA_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_jump_en_i(ex_jump_en_i), .ex_jump_offset_i(ex_jump_offset_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs2_used_i(id_rs2_used_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wen_i(ex_rd_wen_i),
        .dbg_halt_req_i(dbg_halt_req_i), .dbg_step_i(dbg_step_i), .pc_hold_o(pc_hold_o),
        .pc_jump_en_o(pc_jump_en_o), .pc_jump_offset_o(pc_jump_offset_o), .if_id_hold_o(if_id_hold_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o), .dbg_halted_o(dbg_halted_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));
`else
    pipe_ctrl #(.RA_W(RA_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_jump_en_i(ex_jump_en_i), .ex_jump_offset_i(ex_jump_offset_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs2_used_i(id_rs2_used_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wen_i(ex_rd_wen_i),
        .dbg_halt_req_i(dbg_halt_req_i), .dbg_step_i(dbg_step_i), .pc_hold_o(pc_hold_o),
        .pc_jump_en_o(pc_jump_en_o), .pc_jump_offset_o(pc_jump_offset_o), .if_id_hold_o(if_id_hold_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o), .dbg_halted_o(dbg_halted_o));
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: debug mode, single step in flight, bubble after a taken branch.
    bit m_halt, m_step, m_bub;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_halt = 0; m_step = 0; m_bub = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic bit hazard();
        return ex_rd_wen_i && ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                               (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
    endfunction

    task automatic check_outputs();
        bit parked, live, jmp, stl, idle;
        parked = m_halt && !m_step && !m_bub;
        live   = rst_n && !m_bub && !parked;
        jmp    = live && ex_jump_en_i;
        stl    = live && !ex_jump_en_i && hazard();
        idle   = rst_n && parked;
        chk("pc_jump_en", pc_jump_en_o, jmp);
        chk("pc_jump_offset", pc_jump_offset_o, jmp ? ex_jump_offset_i : 0);
        chk("if_id_flush", if_id_flush_o, jmp);
        chk("pc_hold", pc_hold_o, stl || idle);
        chk("if_id_hold", if_id_hold_o, stl || idle);
        chk("id_ex_flush", id_ex_flush_o, jmp || stl || idle);
        chk("dbg_halted", dbg_halted_o, parked);
`ifdef PIPE_CTRL_PERF_CNT_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("flush_cnt", flush_cnt_o, m_flush);
`endif
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            model_clear();
        end else if (m_bub) begin
            m_bub  = 0;
            m_halt = dbg_halt_req_i;
        end else if (m_halt && !m_step) begin
            if (!dbg_halt_req_i) m_halt = 0;
            else if (dbg_step_i) m_step = 1;
        end else if (ex_jump_en_i) begin
            m_bub  = 1;
            m_step = 0;
`ifdef PIPE_CTRL_PERF_CNT_EN
            m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
`endif
        end else begin
`ifdef PIPE_CTRL_PERF_CNT_EN
            if (hazard()) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
`endif
            if (m_step) m_step = 0;
            else m_halt = dbg_halt_req_i;
        end
    endtask

    // One cycle: drive just after posedge, check before next posedge, then advance the model.
    task automatic cyc(input bit rn, input bit jmp, input logic [OFF_W-1:0] off,
                       input logic [RA_W-1:0] a1, input bit u1, input logic [RA_W-1:0] a2, input bit u2,
                       input logic [RA_W-1:0] rd, input bit wen, input bit req, input bit stp);
        rst_n = rn; ex_jump_en_i = jmp; ex_jump_offset_i = off;
        id_rs1_addr_i = a1; id_rs1_used_i = u1; id_rs2_addr_i = a2; id_rs2_used_i = u2;
        ex_rd_addr_i = rd; ex_rd_wen_i = wen; dbg_halt_req_i = req; dbg_step_i = stp;
        if (!rn) model_clear();
        #3;
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    initial begin
        bit req;
        model_clear();
        @(posedge clk); #1;
        cyc(0, 1, 6'h3A, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 6'h15, 3, 1, 0, 0, 3, 1, 1, 0);
        cyc(1, 1, 6'h3A, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6'h11, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 6'h00, 3, 1, 0, 0, 3, 1, 0, 0);
        cyc(1, 0, 6'h00, 3, 0, 0, 0, 3, 1, 0, 0);
        cyc(1, 0, 6'h00, 1, 0, 5, 1, 5, 1, 0, 0);
        cyc(1, 1, 6'h07, 3, 1, 0, 0, 3, 1, 0, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 6'h00, 2, 1, 0, 0, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 1, 6'h2C, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 6'h3F, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 6'h01, 0, 0, 0, 0, 0, 0, 0, 0);
        req = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = !req;
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, OFF_W'($urandom),
                RA_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                RA_W'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                RA_W'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                req, $urandom_range(0, 2) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
